// File: rtl/id_ex_pipeline_register_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_register_if
// Purpose : Bundles every signal crossing the ID/EX boundary so the stage
//           register and its neighbours connect through one port.
// Ports   : parameters DATA_W (operand/PC/immediate width) and CNT_W
//           (bubble statistics counter width).
//           *In    - ID-stage control bundle and operands, plus FlushIn and
//                    HoldIn from the branch unit and the downstream stages.
//           *Out   - registered copy presented to EX, plus DestRegOut.
//           StallOut    - combinational request to freeze PC and IF/ID.
//           BubbleCount - saturating count of inserted bubbles.
// Modports: master = upstream/downstream pipeline environment,
//           slave  = the ID/EX register itself.
// ---------------------------------------------------------------------------
interface id_ex_pipeline_register_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  // Inputs from the ID stage and pipeline control
  logic              ValidIn;
  logic [1:0]        RegDestIn;
  logic              RegWriteIn;
  logic              AluSrcIn;
  logic              MemWriteIn;
  logic              MemReadIn;
  logic              BranchIn;
  logic              BranchSourceMuxIn;
  logic              JALIn;
  logic [1:0]        MemToRegIn;
  logic [1:0]        ByteSelIn;
  logic [2:0]        BCControlIn;
  logic [4:0]        AluOpIn;
  logic [DATA_W-1:0] PCPlus4In;
  logic [DATA_W-1:0] ReadData1In;
  logic [DATA_W-1:0] ReadData2In;
  logic [DATA_W-1:0] ImmExtIn;
  logic [4:0]        RsIn;
  logic [4:0]        RtIn;
  logic [4:0]        RdIn;
  logic              FlushIn;
  logic              HoldIn;

  // Registered outputs toward EX
  logic              ValidOut;
  logic [1:0]        RegDestOut;
  logic              RegWriteOut;
  logic              AluSrcOut;
  logic              MemWriteOut;
  logic              MemReadOut;
  logic              BranchOut;
  logic              BranchSourceMuxOut;
  logic              JALOut;
  logic [1:0]        MemToRegOut;
  logic [1:0]        ByteSelOut;
  logic [2:0]        BCControlOut;
  logic [4:0]        AluOpOut;
  logic [DATA_W-1:0] PCPlus4Out;
  logic [DATA_W-1:0] ReadData1Out;
  logic [DATA_W-1:0] ReadData2Out;
  logic [DATA_W-1:0] ImmExtOut;
  logic [4:0]        RsOut;
  logic [4:0]        RtOut;
  logic [4:0]        RdOut;
  logic [4:0]        DestRegOut;
  logic              StallOut;
  logic [CNT_W-1:0]  BubbleCount;

  modport master (
    output ValidIn, RegDestIn, RegWriteIn, AluSrcIn, MemWriteIn, MemReadIn,
           BranchIn, BranchSourceMuxIn, JALIn, MemToRegIn, ByteSelIn,
           BCControlIn, AluOpIn, PCPlus4In, ReadData1In, ReadData2In,
           ImmExtIn, RsIn, RtIn, RdIn, FlushIn, HoldIn,
    input  ValidOut, RegDestOut, RegWriteOut, AluSrcOut, MemWriteOut,
           MemReadOut, BranchOut, BranchSourceMuxOut, JALOut, MemToRegOut,
           ByteSelOut, BCControlOut, AluOpOut, PCPlus4Out, ReadData1Out,
           ReadData2Out, ImmExtOut, RsOut, RtOut, RdOut, DestRegOut,
           StallOut, BubbleCount
  );

  modport slave (
    input  ValidIn, RegDestIn, RegWriteIn, AluSrcIn, MemWriteIn, MemReadIn,
           BranchIn, BranchSourceMuxIn, JALIn, MemToRegIn, ByteSelIn,
           BCControlIn, AluOpIn, PCPlus4In, ReadData1In, ReadData2In,
           ImmExtIn, RsIn, RtIn, RdIn, FlushIn, HoldIn,
    output ValidOut, RegDestOut, RegWriteOut, AluSrcOut, MemWriteOut,
           MemReadOut, BranchOut, BranchSourceMuxOut, JALOut, MemToRegOut,
           ByteSelOut, BCControlOut, AluOpOut, PCPlus4Out, ReadData1Out,
           ReadData2Out, ImmExtOut, RsOut, RtOut, RdOut, DestRegOut,
           StallOut, BubbleCount
  );
endinterface

// File: rtl/id_ex_pipeline_register.sv
// ---------------------------------------------------------------------------
// id_ex_pipeline_register
// Purpose : ID/EX stage register. Captures the decoded control bundle and
//           operands, detects load-use hazards against the instruction in
//           EX, inserts bubbles on flush or hazard, freezes on a downstream
//           hold, and counts inserted bubbles (saturating).
// Ports   : Clock - rising-edge clock.
//           Reset - synchronous, active-high; clears every register.
//           bus   - id_ex_pipeline_register_if.slave carrying all ID-stage
//                   inputs, FlushIn/HoldIn, registered *Out fields,
//                   DestRegOut, StallOut and BubbleCount.
// ---------------------------------------------------------------------------
module id_ex_pipeline_register #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic Clock,
  input  logic Reset,
  id_ex_pipeline_register_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [1:0]        regDest;
    logic              regWrite;
    logic              aluSrc;
    logic              memWrite;
    logic              memRead;
    logic              branch;
    logic              branchSourceMux;
    logic              jal;
    logic [1:0]        memToReg;
    logic [1:0]        byteSel;
    logic [2:0]        bcControl;
    logic [4:0]        aluOp;
    logic [DATA_W-1:0] pcPlus4;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic [DATA_W-1:0] immExt;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        destReg;
  } stage_t;

  stage_t           stage_q, stage_d, stageIn;
  logic [CNT_W-1:0] bubbleCount_q, bubbleCount_d;
  logic             loadUse;

  // Assemble the incoming instruction. The EX destination is resolved here
  // so DestRegOut comes straight from a flop; the unused RegDest code 11
  // resolves to r0, which the hazard check and writeback both ignore.
  always_comb begin
    stageIn                 = '0;
    stageIn.valid           = bus.ValidIn;
    stageIn.regDest         = bus.RegDestIn;
    stageIn.regWrite        = bus.RegWriteIn;
    stageIn.aluSrc          = bus.AluSrcIn;
    stageIn.memWrite        = bus.MemWriteIn;
    stageIn.memRead         = bus.MemReadIn;
    stageIn.branch          = bus.BranchIn;
    stageIn.branchSourceMux = bus.BranchSourceMuxIn;
    stageIn.jal             = bus.JALIn;
    stageIn.memToReg        = bus.MemToRegIn;
    stageIn.byteSel         = bus.ByteSelIn;
    stageIn.bcControl       = bus.BCControlIn;
    stageIn.aluOp           = bus.AluOpIn;
    stageIn.pcPlus4         = bus.PCPlus4In;
    stageIn.readData1       = bus.ReadData1In;
    stageIn.readData2       = bus.ReadData2In;
    stageIn.immExt          = bus.ImmExtIn;
    stageIn.rs              = bus.RsIn;
    stageIn.rt              = bus.RtIn;
    stageIn.rd              = bus.RdIn;
    case (bus.RegDestIn)
      2'b00:   stageIn.destReg = bus.RdIn;
      2'b01:   stageIn.destReg = bus.RtIn;
      2'b10:   stageIn.destReg = 5'd31;
      default: stageIn.destReg = 5'd0;
    endcase
  end

  // A load in EX whose result the ID instruction needs cannot be forwarded
  // in time; writes to r0 never create a dependency.
  assign loadUse = bus.ValidIn & stage_q.valid & stage_q.memRead &
                   stage_q.regWrite & (stage_q.destReg != 5'd0) &
                   ((stage_q.destReg == bus.RsIn) | (stage_q.destReg == bus.RtIn));

  // A flush squashes the ID instruction anyway, so it must not also stall it.
  assign bus.StallOut = bus.HoldIn | (loadUse & ~bus.FlushIn);

  // Next state: hold freezes everything; flush or hazard inserts a counted
  // bubble; otherwise capture, with an invalid input collapsing to an
  // all-zero (uncounted) bubble so EX never sees stray control bits.
  always_comb begin
    stage_d       = stage_q;
    bubbleCount_d = bubbleCount_q;
    if (!bus.HoldIn) begin
      if (bus.FlushIn || loadUse) begin
        stage_d = '0;
        if (bubbleCount_q != {CNT_W{1'b1}}) begin
          bubbleCount_d = bubbleCount_q + CNT_W'(1);
        end
      end else if (bus.ValidIn) begin
        stage_d = stageIn;
      end else begin
        stage_d = '0;
      end
    end
  end

  // Stage and statistics registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stage_q       <= '0;
      bubbleCount_q <= '0;
    end else begin
      stage_q       <= stage_d;
      bubbleCount_q <= bubbleCount_d;
    end
  end

  assign bus.ValidOut           = stage_q.valid;
  assign bus.RegDestOut         = stage_q.regDest;
  assign bus.RegWriteOut        = stage_q.regWrite;
  assign bus.AluSrcOut          = stage_q.aluSrc;
  assign bus.MemWriteOut        = stage_q.memWrite;
  assign bus.MemReadOut         = stage_q.memRead;
  assign bus.BranchOut          = stage_q.branch;
  assign bus.BranchSourceMuxOut = stage_q.branchSourceMux;
  assign bus.JALOut             = stage_q.jal;
  assign bus.MemToRegOut        = stage_q.memToReg;
  assign bus.ByteSelOut         = stage_q.byteSel;
  assign bus.BCControlOut       = stage_q.bcControl;
  assign bus.AluOpOut           = stage_q.aluOp;
  assign bus.PCPlus4Out         = stage_q.pcPlus4;
  assign bus.ReadData1Out       = stage_q.readData1;
  assign bus.ReadData2Out       = stage_q.readData2;
  assign bus.ImmExtOut          = stage_q.immExt;
  assign bus.RsOut              = stage_q.rs;
  assign bus.RtOut              = stage_q.rt;
  assign bus.RdOut              = stage_q.rd;
  assign bus.DestRegOut         = stage_q.destReg;
  assign bus.BubbleCount        = bubbleCount_q;

endmodule
